// File: rtl/ifu_pkg.sv
// Shared widths, reset default and the prefetch queue payload for the ifu.
package ifu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; used for the instruction queue and the request PC tags.
module ifu_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & ~empty;
  assign rdata   = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[PTR_W'(i)] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && !flush && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && !flush && empty));

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: credit-limited word fetch, PC-tagged prefetch queue, redirect flush.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  fetch_pc_nxt;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] out_cnt_nxt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] drop_cnt_nxt;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] q_count_nxt;
  logic [CNT_W-1:0] tag_count;
  logic             req_q;
  logic             req_nxt;
  logic             grant;
  logic             resp_stale;
  logic             q_push;
  logic             q_pop;
  logic             q_full;
  logic             q_empty;
  logic             tag_full;
  logic             tag_empty;
  logic [XLEN-1:0]  tag_pc;
  fetch_entry_t     q_wdata;
  fetch_entry_t     q_rdata;

  assign grant      = req_q & imem_gnt_i;
  assign resp_stale = redirect_i | (drop_cnt != '0);
  assign q_push     = imem_rvalid_i & ~resp_stale;
  assign q_pop      = ~q_empty & inst_ready_i;
  assign q_wdata    = '{pc: tag_pc, inst: imem_rdata_i};

  // Next-state view; the request flag is registered from it so the credit check stays exact.
  always_comb begin
    fetch_pc_nxt = fetch_pc;
    drop_cnt_nxt = drop_cnt;
    out_cnt_nxt  = out_cnt + CNT_W'(grant) - CNT_W'(imem_rvalid_i);
    q_count_nxt  = redirect_i ? '0 : q_count + CNT_W'(q_push) - CNT_W'(q_pop);
    if (redirect_i) begin
      fetch_pc_nxt = redirect_pc_i & ~XLEN'(3);
      drop_cnt_nxt = out_cnt_nxt;
    end else begin
      if (grant) fetch_pc_nxt = fetch_pc + XLEN'(4);
      if (imem_rvalid_i && (drop_cnt != '0)) drop_cnt_nxt = drop_cnt - CNT_W'(1);
    end
    req_nxt = (SUM_W'(q_count_nxt) + SUM_W'(out_cnt_nxt)) < SUM_W'(FIFO_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      req_q    <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      out_cnt  <= out_cnt_nxt;
      drop_cnt <= drop_cnt_nxt;
      req_q    <= req_nxt;
    end
  end

  // PC of every granted request, popped in order as responses return (stale ones included).
  ifu_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant),
    .pop   (imem_rvalid_i),
    .flush (1'b0),
    .wdata (fetch_pc),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  ifu_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_i),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign imem_req_o   = req_q;
  assign imem_addr_o  = fetch_pc;
  assign inst_valid_o = ~q_empty;
  assign inst_o       = q_rdata.inst;
  assign inst_pc_o    = q_rdata.pc;

  a_credit: assert property (@(posedge clk) disable iff (!rst_n) !(grant && tag_full));
  a_no_orphan: assert property (@(posedge clk) disable iff (!rst_n) !(imem_rvalid_i && tag_empty));
  a_tag_track: assert property (@(posedge clk) disable iff (!rst_n) tag_count == out_cnt);
  a_q_room: assert property (@(posedge clk) disable iff (!rst_n) !(q_push && q_full));

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: reset, streaming, back-pressure, redirects, grant stalls, PC wrap.
module tb_ifu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic        w_gnt = 1'b1;
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = '0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned lat = 1;
  int unsigned cyc = 0;

  ifu #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(4)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i)
  );

  ifu #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (w_zero),
    .redirect_pc_i (w_zero32),
    .imem_req_o    (w_req),
    .imem_addr_o   (w_addr),
    .imem_gnt_i    (w_gnt),
    .imem_rvalid_i (w_zero),
    .imem_rdata_i  (w_zero32),
    .inst_valid_o  (w_valid),
    .inst_o        (w_inst),
    .inst_pc_o     (w_pc),
    .inst_ready_i  (w_zero)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // In-order memory model: each granted address answers lat cycles later.
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;
  pend_t pend_q[$];

  always @(posedge clk) begin
    if (!rst_n) pend_q.delete();
    else begin
      if (imem_rvalid_i && pend_q.size() != 0) void'(pend_q.pop_front());
      if (imem_req_o && imem_gnt_i) pend_q.push_back('{addr: imem_addr_o, due: cyc + lat});
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = word_at(pend_q[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Returns at the negedge of cycle 0, the first cycle with reset released.
  task automatic do_reset(input logic gnt, input logic rdy, input int unsigned l);
    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = gnt;
    inst_ready_i  = rdy;
    lat           = l;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Streaming with 1-cycle memory, plus the wrap instance in lockstep.
    do_reset(1'b1, 1'b1, 1);
    chk1 ("c0_req",      imem_req_o,   1'b0);
    chk1 ("c0_valid",    inst_valid_o, 1'b0);
    chk32("c0_addr",     imem_addr_o,  32'h0000_0100);
    chk32("c0_inst",     inst_o,       32'h0);
    chk32("c0_pc",       inst_pc_o,    32'h0);
    chk32("wrap_c0",     w_addr,       32'hFFFF_FFF8);
    chk1 ("wrap_c0_req", w_req,        1'b0);
    chk32("wrap_c0_pc",  w_pc,         32'h0);
    chk32("wrap_c0_ins", w_inst,       32'h0);
    tick();
    chk1 ("c1_req",      imem_req_o,   1'b1);
    chk32("c1_addr",     imem_addr_o,  32'h0000_0100);
    chk1 ("c1_valid",    inst_valid_o, 1'b0);
    chk32("wrap_c1",     w_addr,       32'hFFFF_FFF8);
    chk1 ("wrap_c1_req", w_req,        1'b1);
    tick();
    chk32("c2_addr",     imem_addr_o,  32'h0000_0104);
    chk1 ("c2_valid",    inst_valid_o, 1'b0);
    chk32("wrap_c2",     w_addr,       32'hFFFF_FFFC);
    tick();
    chk32("wrap_c3",     w_addr,       32'h0000_0000);
    chk1 ("wrap_valid",  w_valid,      1'b0);
    chk32("c3_addr",     imem_addr_o,  32'h0000_0108);
    for (int k = 0; k < 4; k++) begin
      chk1 ("stream_valid", inst_valid_o, 1'b1);
      chk32("stream_pc",    inst_pc_o,    32'h0000_0100 + 32'(4 * k));
      chk32("stream_inst",  inst_o,       word_at(32'h0000_0100 + 32'(4 * k)));
      tick();
    end

    // Back-pressure: credits cap at four, then drain in order.
    do_reset(1'b1, 1'b0, 1);
    repeat (8) tick();
    chk1 ("bp_req",   imem_req_o,   1'b0);
    chk1 ("bp_valid", inst_valid_o, 1'b1);
    chk32("bp_addr",  imem_addr_o,  32'h0000_0110);
    chk32("bp_head",  inst_pc_o,    32'h0000_0100);
    inst_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk1 ("drain_valid", inst_valid_o, 1'b1);
      chk32("drain_pc",    inst_pc_o,    32'h0000_0100 + 32'(4 * k));
      chk32("drain_inst",  inst_o,       word_at(32'h0000_0100 + 32'(4 * k)));
      tick();
    end

    // Redirect with three requests in flight (4-cycle memory).
    do_reset(1'b1, 1'b1, 4);
    repeat (4) tick();
    chk1 ("r3_req_pre",  imem_req_o,  1'b1);
    chk32("r3_addr_pre", imem_addr_o, 32'h0000_010C);
    imem_gnt_i    = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_2002;
    tick();
    redirect_i = 1'b0;
    imem_gnt_i = 1'b1;
    chk32("r3_addr", imem_addr_o, 32'h0000_2000);
    chk1 ("r3_req",  imem_req_o,  1'b1);
    for (int k = 0; k < 5; k++) begin
      chk1("r3_flushed", inst_valid_o, 1'b0);
      tick();
    end
    chk1 ("r3_valid", inst_valid_o, 1'b1);
    chk32("r3_pc",    inst_pc_o,    32'h0000_2000);
    chk32("r3_inst",  inst_o,       word_at(32'h0000_2000));
    tick();
    chk32("r3_pc2",   inst_pc_o,    32'h0000_2004);

    // Redirect coinciding with a response and a grant.
    do_reset(1'b1, 1'b1, 1);
    repeat (2) tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_3000;
    tick();
    redirect_i = 1'b0;
    chk32("r4_addr",   imem_addr_o,  32'h0000_3000);
    chk1 ("r4_req",    imem_req_o,   1'b1);
    chk1 ("r4_valid3", inst_valid_o, 1'b0);
    tick();
    chk1 ("r4_valid4", inst_valid_o, 1'b0);
    chk32("r4_addr4",  imem_addr_o,  32'h0000_3004);
    tick();
    chk1 ("r4_valid5", inst_valid_o, 1'b1);
    chk32("r4_pc5",    inst_pc_o,    32'h0000_3000);
    tick();
    chk32("r4_pc6",    inst_pc_o,    32'h0000_3004);

    // Grant withheld for five cycles.
    do_reset(1'b0, 1'b1, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk1 ("stall_req",  imem_req_o,  1'b1);
      chk32("stall_addr", imem_addr_o, 32'h0000_0100);
    end
    tick();
    chk32("stall_addr6", imem_addr_o, 32'h0000_0100);
    imem_gnt_i = 1'b1;
    tick();
    chk32("stall_addr7", imem_addr_o,  32'h0000_0104);
    chk1 ("stall_valid", inst_valid_o, 1'b0);
    tick();
    chk1 ("stall_out",   inst_valid_o, 1'b1);
    chk32("stall_pc",    inst_pc_o,    32'h0000_0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
